cook_timer_down: RTL
====================

Name: cook_timer_down

Overview:
- Countdown counterpart to the 0→7 up-counter: loads a BCD mm:ss cook time and decrements it once per `tick_en` strobe until 00:00.
- On expiry it pulses `done` and holds `beep` for a fixed number of ticks.
- Sits between keypad/control logic and the display/magnetron enable in the microwave datapath.
- Supports start, pause, door-open and cancel.

Parameters:
- BEEP_TICKS, 3, number of `tick_en` strobes `beep` stays high after expiry (1..15).
- MAX_MIN, 99, maximum loadable minutes value (BCD, ≤ 99).

Ports:
- clk  in  1  system clock, all logic on posedge.
- clear_n  in  1  synchronous active-low reset.
- tick_en  in  1  one-cycle 1 Hz strobe from the prescaler.
- load  in  1  load `load_time` into the timer (IDLE only).
- load_time  in  16  BCD {m_hi, m_lo, s_hi, s_lo}.
- start  in  1  start or resume counting.
- pause  in  1  pause counting.
- cancel  in  1  abort; time cleared to 00:00.
- door_open  in  1  level; forces pause while high.
- add30  in  1  +30 s request (see Optional Feature).
- time_left  out  16  current BCD mm:ss.
- running  out  1  high in RUN.
- paused  out  1  high in PAUSE.
- done  out  1  one-cycle pulse when the count reaches 00:00.
- beep  out  1  high in DONE.

Behaviour:
- Reset: `clear_n` low at posedge → state IDLE, `time_left` = 16'h0000, `running` = `paused` = `done` = `beep` = 0, beep counter = 0. Reset is legal mid-RUN or mid-DONE and gives the same result.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered. Outputs reflect a new state the cycle after the causing input.
- Per-cycle priority: cancel > door_open > pause > start > add30 > load > tick_en.
- IDLE:
  - `load` with valid BCD (every digit ≤ 9, s_hi ≤ 5, minutes ≤ MAX_MIN) → `time_left` = `load_time`.
  - Invalid `load_time` → ignored; value unchanged.
  - `start` with `time_left` ≠ 0 and `door_open` = 0 → RUN.
  - `start` at 00:00 or with the door open → ignored.
- RUN:
  - `tick_en` → decrement one second.
  - If the decrement produces 00:00 → DONE, with `done` = 1 for exactly that one cycle.
  - `pause` or `door_open` → PAUSE with no decrement that cycle, even if `tick_en` is coincident.
  - `cancel` → IDLE, `time_left` = 0.
  - `load` is ignored.
- PAUSE:
  - Time is frozen; `tick_en` is ignored.
  - `start` with `door_open` = 0 → RUN.
  - `cancel` → IDLE with time cleared.
- DONE:
  - `beep` = 1. Beep counter increments on `tick_en`; on reaching BEEP_TICKS → IDLE, `beep` = 0.
  - `cancel` → IDLE immediately.
  - `start`, `load` and `pause` are ignored.
- Decrement arithmetic:
  - s_lo 0 → 9 with borrow.
  - s_hi 0 → 5 with borrow.
  - m_lo 0 → 9 with borrow.
  - m_hi decrements on borrow.
  - Never decrements below 00:00.
- Counting from loaded value T to 00:00 takes exactly T `tick_en` strobes in RUN.

Optional Feature:
- Macro: ADD_30S_EN.
- Defined:
  - `add30` in RUN or PAUSE adds 30 s in BCD (s_hi + 3, carry to minutes when the result ≥ 60), saturating at MAX_MIN:59.
  - `add30` in IDLE at 00:00 with the door closed loads 00:30 and enters RUN (quick start).
  - `add30` in IDLE with time ≠ 0 adds 30 s only.
  - `add30` in DONE is ignored.
  - `add30` coincident with `tick_en` in RUN: add 30 s, then decrement 1 s (net +29 s).
- Undefined: `add30` is ignored entirely; the port stays in the interface.

Decomposition:
- Shared package `microwave_pkg`:
  - state enum {IDLE, RUN, PAUSE, DONE}.
  - BCD digit typedef (4-bit).
  - mm:ss time typedef (16-bit).
  - constants SEC_HI_MAX = 5, DIGIT_MAX = 9, TIME_ZERO = 16'h0000.
- Sub-module `bcd_digit_down`:
  - parameterised modulus digit (wrap value 9 or 5).
  - inputs: dec_in, load, load_val.
  - outputs: digit, borrow_out.
  - four instances chained by borrow.

Test Plan:
- Load 16'h0005, start, apply 5 `tick_en` → `time_left` 4,3,2,1,0; `done` pulses once on the 5th tick; `beep` high for 3 ticks, then IDLE.
- Load 16'h0100 (01:00), start, 1 tick → 16'h0059; load 16'h1000, run 1 tick → 16'h0959.
- RUN at 00:20; `pause` and `tick_en` in the same cycle → PAUSE, `time_left` stays 00:20. Raise `door_open`, then `start` → no resume. Lower `door_open`, then `start` → RUN.
- Invalid loads 16'h0060 and 16'h00A0 → ignored, time unchanged. Load during RUN → ignored. `cancel` in RUN → IDLE, 00:00, `done` never asserted.
- `clear_n` low for 1 cycle mid-RUN at 00:07 → all outputs 0 and state IDLE the next cycle.
- With ADD_30S_EN: `add30` in IDLE at 00:00 → RUN at 00:30. `add30` at 00:45 → 01:15. `add30` at 99:50 → 99:59. Without the macro, the same stimulus leaves the state unchanged.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave cook-timer datapath.
package microwave_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    typedef logic [3:0]  bcd_t;
    typedef logic [15:0] mmss_t;

    localparam bcd_t  SEC_HI_MAX = 4'd5;
    localparam bcd_t  DIGIT_MAX  = 4'd9;
    localparam mmss_t TIME_ZERO  = 16'h0000;
    localparam mmss_t TIME_ONE   = 16'h0001;
    localparam mmss_t TIME_30S   = 16'h0030;

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit; load takes effect before a same-cycle decrement.
// borrow_out flags that the digit about to be decremented is zero.
module bcd_digit_down
    import microwave_pkg::*;
#(
    parameter bcd_t WRAP = DIGIT_MAX
) (
    input  logic clk,
    input  logic clear_n,
    input  logic dec_in,
    input  logic load,
    input  bcd_t load_val,
    output bcd_t digit,
    output logic borrow_out
);

    bcd_t digit_q;
    bcd_t digit_d;
    bcd_t base;

    always_comb begin
        base    = load ? load_val : digit_q;
        digit_d = base;
        if (dec_in) begin
            digit_d = (base == 4'd0) ? WRAP : base - 4'd1;
        end
    end

    assign borrow_out = (base == 4'd0);
    assign digit      = digit_q;

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/cook_timer_down.sv
// BCD mm:ss cook-time countdown with start/pause/door/cancel and expiry beep.
// Optional +30 s button behaviour is compiled in with `define ADD_30S_EN.
module cook_timer_down
    import microwave_pkg::*;
#(
    parameter int BEEP_TICKS = 3,
    parameter int MAX_MIN    = 99
) (
    input  logic        clk,
    input  logic        clear_n,
    input  logic        tick_en,
    input  logic        load,
    input  logic [15:0] load_time,
    input  logic        start,
    input  logic        pause,
    input  logic        cancel,
    input  logic        door_open,
    input  logic        add30,
    output logic [15:0] time_left,
    output logic        running,
    output logic        paused,
    output logic        done,
    output logic        beep
);

    localparam bcd_t  BEEP_LAST = bcd_t'(BEEP_TICKS);
    localparam mmss_t TIME_MAX  = {bcd_t'(MAX_MIN / 10), bcd_t'(MAX_MIN % 10), 4'h5, 4'h9};

    state_t state_q, state_d;
    bcd_t   beep_cnt_q, beep_cnt_d;
    logic   running_q, paused_q, done_q, beep_q, done_d;

    mmss_t  time_q, base, t_load_val;
    logic   t_load, t_dec;
    logic   dec_s_hi, dec_m_lo, dec_m_hi;
    logic   brw_s_lo, brw_s_hi, brw_m_lo, unused_brw_m_hi;

    function automatic logic load_valid(mmss_t t);
        int mins;
        mins = 10 * int'(t[15:12]) + int'(t[11:8]);
        return (t[15:12] <= DIGIT_MAX) && (t[11:8] <= DIGIT_MAX) &&
               (t[7:4] <= SEC_HI_MAX) && (t[3:0] <= DIGIT_MAX) && (mins <= MAX_MIN);
    endfunction

`ifdef ADD_30S_EN
    function automatic mmss_t add_30s(mmss_t t);
        bcd_t m_hi, m_lo, s_hi;
        int   mins;
        m_hi = t[15:12];
        m_lo = t[11:8];
        s_hi = t[7:4] + 4'd3;
        if (s_hi > SEC_HI_MAX) begin
            s_hi = s_hi - 4'd6;
            mins = 10 * int'(m_hi) + int'(m_lo) + 1;
            if (mins > MAX_MIN) return TIME_MAX;
            if (m_lo == DIGIT_MAX) begin
                m_lo = 4'd0;
                m_hi = m_hi + 4'd1;
            end else begin
                m_lo = m_lo + 4'd1;
            end
        end
        return {m_hi, m_lo, s_hi, t[3:0]};
    endfunction
`else
    logic unused_add30;
    assign unused_add30 = add30;
`endif

    always_comb begin
        state_d    = state_q;
        beep_cnt_d = beep_cnt_q;
        done_d     = 1'b0;
        t_load     = 1'b0;
        t_load_val = time_q;
        t_dec      = 1'b0;
        base       = time_q;
        if (cancel) begin
            state_d    = IDLE;
            t_load     = 1'b1;
            t_load_val = TIME_ZERO;
            beep_cnt_d = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && time_q != TIME_ZERO && !door_open) begin
                        state_d = RUN;
                    end
`ifdef ADD_30S_EN
                    else if (add30 && time_q == TIME_ZERO && !door_open) begin
                        t_load     = 1'b1;
                        t_load_val = TIME_30S;
                        state_d    = RUN;
                    end else if (add30 && time_q != TIME_ZERO) begin
                        t_load     = 1'b1;
                        t_load_val = add_30s(time_q);
                    end
`endif
                    else if (load && load_valid(load_time)) begin
                        t_load     = 1'b1;
                        t_load_val = load_time;
                    end
                end
                RUN: begin
                    if (door_open || pause) begin
                        state_d = PAUSE;
                    end else begin
`ifdef ADD_30S_EN
                        if (add30) begin
                            t_load     = 1'b1;
                            t_load_val = add_30s(time_q);
                        end
`endif
                        // Decrement acts on the post-add30 value so a coincident add nets +29 s.
                        base = t_load ? t_load_val : time_q;
                        if (tick_en && base != TIME_ZERO) begin
                            t_dec = 1'b1;
                            if (base == TIME_ONE) begin
                                state_d    = DONE;
                                done_d     = 1'b1;
                                beep_cnt_d = 4'd0;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (start && !door_open) begin
                        state_d = RUN;
                    end
`ifdef ADD_30S_EN
                    else if (add30) begin
                        t_load     = 1'b1;
                        t_load_val = add_30s(time_q);
                    end
`endif
                end
                DONE: begin
                    if (tick_en) begin
                        beep_cnt_d = beep_cnt_q + 4'd1;
                        if (beep_cnt_d == BEEP_LAST) begin
                            state_d    = IDLE;
                            beep_cnt_d = 4'd0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q    <= IDLE;
            beep_cnt_q <= 4'd0;
            running_q  <= 1'b0;
            paused_q   <= 1'b0;
            done_q     <= 1'b0;
            beep_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beep_cnt_q <= beep_cnt_d;
            running_q  <= (state_d == RUN);
            paused_q   <= (state_d == PAUSE);
            done_q     <= done_d;
            beep_q     <= (state_d == DONE);
        end
    end

    assign dec_s_hi = t_dec & brw_s_lo;
    assign dec_m_lo = dec_s_hi & brw_s_hi;
    assign dec_m_hi = dec_m_lo & brw_m_lo;

    bcd_digit_down #(.WRAP(DIGIT_MAX)) u_s_lo (
        .clk(clk), .clear_n(clear_n), .dec_in(t_dec), .load(t_load),
        .load_val(t_load_val[3:0]), .digit(time_q[3:0]), .borrow_out(brw_s_lo)
    );
    bcd_digit_down #(.WRAP(SEC_HI_MAX)) u_s_hi (
        .clk(clk), .clear_n(clear_n), .dec_in(dec_s_hi), .load(t_load),
        .load_val(t_load_val[7:4]), .digit(time_q[7:4]), .borrow_out(brw_s_hi)
    );
    bcd_digit_down #(.WRAP(DIGIT_MAX)) u_m_lo (
        .clk(clk), .clear_n(clear_n), .dec_in(dec_m_lo), .load(t_load),
        .load_val(t_load_val[11:8]), .digit(time_q[11:8]), .borrow_out(brw_m_lo)
    );
    bcd_digit_down #(.WRAP(DIGIT_MAX)) u_m_hi (
        .clk(clk), .clear_n(clear_n), .dec_in(dec_m_hi), .load(t_load),
        .load_val(t_load_val[15:12]), .digit(time_q[15:12]), .borrow_out(unused_brw_m_hi)
    );

    assign time_left = time_q;
    assign running   = running_q;
    assign paused    = paused_q;
    assign done      = done_q;
    assign beep      = beep_q;

endmodule
